// File: rtl/microsoc_debug_pkg.sv
// Shared debug-port definitions: FSM state encoding and the default word width
// used by microsoc_top.
package microsoc_debug_pkg;
    localparam int DEBUG_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        GAP    = 2'd3
    } dbg_state_t;
endpackage

// File: rtl/debugport_fifo.sv
// Synchronous FIFO for queued debug words; flush discards every stored entry.
module debugport_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;

    // Storage has no reset; pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    assign rd_data = mem[rptr];
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
endmodule

// File: rtl/debugport_ctrl.sv
// Paced debug-port driver: queues processor writes and emits each word with a
// setup cycle, a fixed-length strobe and an inter-word gap.
module debugport_ctrl
    import microsoc_debug_pkg::*;
#(
    parameter int DATA_W        = DEBUG_DATA_W,
    parameter int DEPTH         = 4,
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1,
    parameter bit DROP_ON_FULL  = 1'b0,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   flush,
    output logic                   debugport_en,
    output logic [DATA_W-1:0]      debugport,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int MAXC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] S_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    dbg_state_t        state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              full, empty, push, pop, drop, can_pop, word_done;
    logic [DATA_W-1:0] head;

    assign wr_ready = !rst && (DROP_ON_FULL ? 1'b1 : !full);
    assign push     = wr_valid && wr_ready && !full && !flush;
    assign drop     = DROP_ON_FULL && wr_valid && wr_ready && full && !flush;
    // A flush also discards the head, so nothing may be popped on that edge.
    assign can_pop  = !empty && !flush;
    assign busy     = (state != IDLE) || (level != '0);

    debugport_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (wr_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        word_done = 1'b0;
        case (state)
            IDLE:   word_done = 1'b1;
            SETUP: begin
                state_nxt = STROBE;
                cnt_nxt   = '0;
            end
            STROBE: begin
                if (cnt == S_LAST) begin
                    cnt_nxt = '0;
                    if (GAP_CYCLES > 0) state_nxt = GAP;
                    else                word_done = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == G_LAST) word_done = 1'b1;
                else               cnt_nxt   = cnt + CW'(1);
            end
            default: state_nxt = IDLE;
        endcase
        // End of a word (or idling): fetch the next one if available.
        if (word_done) begin
            cnt_nxt = '0;
            if (can_pop) begin
                pop       = 1'b1;
                state_nxt = SETUP;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            debugport_en <= 1'b0;
            debugport    <= '0;
            drop_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            debugport_en <= (state_nxt == STROBE);
            if (pop)
                debugport <= head;
            if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_debugport_ctrl.sv
// Directed bench for debugport_ctrl: default-parameter instance plus a
// drop-on-full instance with a long strobe and a 2-bit drop counter.
module tb_debugport_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid, flush;
    logic [7:0] wr_data;
    logic       wr_ready, en, busy;
    logic [7:0] dp, drop_cnt;
    logic [2:0] level;

    logic       d_valid, d_flush;
    logic [7:0] d_data;
    logic       d_ready, d_en, d_busy;
    logic [7:0] d_dp;
    logic [1:0] d_drop;
    logic [2:0] d_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debugport_ctrl #(.DATA_W(8), .DEPTH(4), .STROBE_CYCLES(2), .GAP_CYCLES(1),
                     .DROP_ON_FULL(1'b0), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .flush(flush), .debugport_en(en), .debugport(dp),
        .level(level), .busy(busy), .drop_cnt(drop_cnt)
    );

    debugport_ctrl #(.DATA_W(8), .DEPTH(4), .STROBE_CYCLES(16), .GAP_CYCLES(1),
                     .DROP_ON_FULL(1'b1), .CNT_W(2)) u_drop (
        .clk(clk), .rst(rst), .wr_valid(d_valid), .wr_ready(d_ready),
        .wr_data(d_data), .flush(d_flush), .debugport_en(d_en), .debugport(d_dp),
        .level(d_level), .busy(d_busy), .drop_cnt(d_drop)
    );

    // Pulse monitors: word at each rising strobe, strobe width, low cycles before it.
    logic [7:0] words[$], d_words[$];
    int widths[$], gaps[$], d_widths[$];
    logic prev_en = 1'b0, d_prev_en = 1'b0;
    int hicnt = 0, lowcnt = 0, d_hicnt = 0;

    always @(negedge clk) begin
        if (en) begin
            if (!prev_en) begin
                words.push_back(dp);
                gaps.push_back(lowcnt);
                hicnt = 0;
            end
            hicnt++;
        end else begin
            if (prev_en) begin
                widths.push_back(hicnt);
                lowcnt = 0;
            end
            lowcnt++;
        end
        prev_en = en;
        if (d_en) begin
            if (!d_prev_en) begin
                d_words.push_back(d_dp);
                d_hicnt = 0;
            end
            d_hicnt++;
        end else if (d_prev_en) begin
            d_widths.push_back(d_hicnt);
        end
        d_prev_en = d_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        words.delete();
        widths.delete();
        gaps.delete();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) tick();
        chk(tag, busy, 0);
    endtask

    task automatic wait_d_idle(input string tag);
        for (int i = 0; i < 400 && d_busy; i++) tick();
        chk(tag, d_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; flush = 1'b0;
        d_valid = 1'b0; d_data = '0; d_flush = 1'b0;
        tick(); tick();
        chk("rst_en", en, 0);
        chk("rst_dp", dp, 0);
        chk("rst_level", level, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", wr_ready, 0);
        rst = 1'b0;
        tick();
        chk("ready_out_of_rst", wr_ready, 1);

        // Single word latency: push at edge N.
        clear_mon();
        wr_data = 8'hA5; wr_valid = 1'b1;
        tick();                      // N
        wr_valid = 1'b0;
        chk("a5_n_level", level, 1);
        chk("a5_n_en", en, 0);
        chk("a5_n_busy", busy, 1);
        tick();                      // N+1
        chk("a5_n1_dp", dp, 8'hA5);
        chk("a5_n1_en", en, 0);
        chk("a5_n1_level", level, 0);
        tick();                      // N+2
        chk("a5_n2_en", en, 1);
        tick();                      // N+3
        chk("a5_n3_en", en, 1);
        tick();                      // N+4
        chk("a5_n4_en", en, 0);
        chk("a5_n4_dp_hold", dp, 8'hA5);
        chk("a5_n4_busy", busy, 1);
        tick();                      // N+5
        chk("a5_n5_busy", busy, 0);
        chk("a5_words", words.size(), 1);
        chk("a5_width", widths.size() > 0 ? widths[0] : -1, 2);

        // Burst of five, FIFO fills on the fifth write.
        tick(); tick();
        clear_mon();
        for (int k = 1; k <= 5; k++) begin
            wr_data = 8'(k); wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        chk("burst_full_level", level, 4);
        chk("burst_full_ready", wr_ready, 0);
        tick();
        chk("burst_after_pop_level", level, 3);
        chk("burst_after_pop_ready", wr_ready, 1);
        wait_idle("burst_idle");
        chk("burst_count", words.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < words.size()) chk($sformatf("burst_word%0d", k), words[k], 8'(k + 1));
            if (k < widths.size()) chk($sformatf("burst_width%0d", k), widths[k], 2);
            if (k > 0 && k < gaps.size()) chk($sformatf("burst_gap%0d", k), gaps[k], 2);
        end

        // Flush during strobe, with a simultaneous push that must vanish.
        tick();
        clear_mon();
        wr_data = 8'h21; wr_valid = 1'b1; tick();   // P
        wr_data = 8'h22; tick();                    // P+1
        wr_data = 8'h23; tick();                    // P+2
        chk("flush_pre_en", en, 1);
        chk("flush_pre_level", level, 2);
        wr_data = 8'h24; flush = 1'b1; tick();      // P+3
        wr_valid = 1'b0; flush = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_en_held", en, 1);
        chk("flush_drop", drop_cnt, 0);
        tick();                                     // P+4
        chk("flush_en_fall", en, 0);
        wait_idle("flush_idle");
        chk("flush_words", words.size(), 1);
        chk("flush_word0", words.size() > 0 ? words[0] : 8'hFF, 8'h21);
        chk("flush_width", widths.size() > 0 ? widths[0] : -1, 2);

        // Reset asserted mid-strobe with a word still queued.
        tick();
        wr_data = 8'h31; wr_valid = 1'b1; tick();   // Q
        wr_data = 8'h32; tick();                    // Q+1
        wr_valid = 1'b0; tick();                    // Q+2
        chk("rstmid_pre_en", en, 1);
        chk("rstmid_pre_level", level, 1);
        rst = 1'b1; tick();                         // Q+3
        chk("rstmid_en", en, 0);
        chk("rstmid_dp", dp, 0);
        chk("rstmid_level", level, 0);
        chk("rstmid_drop", drop_cnt, 0);
        chk("rstmid_ready", wr_ready, 0);
        rst = 1'b0; tick();
        clear_mon();
        wr_data = 8'h3C; wr_valid = 1'b1; tick();
        wr_valid = 1'b0;
        wait_idle("rstmid_idle");
        chk("rstmid_words", words.size(), 1);
        chk("rstmid_word0", words.size() > 0 ? words[0] : 8'hFF, 8'h3C);
        chk("rstmid_width", widths.size() > 0 ? widths[0] : -1, 2);

        // Drop-on-full instance: ten writes, five kept, drop counter saturates at 3.
        tick();
        d_words.delete(); d_widths.delete();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("drop_ready%0d", k), d_ready, 1);
            d_data = 8'h10 + 8'(k); d_valid = 1'b1;
            tick();
            if (k == 7) chk("drop_cnt_after8", d_drop, 3);
        end
        d_valid = 1'b0;
        chk("drop_cnt_sat", d_drop, 3);
        chk("drop_level", d_level, 4);
        wait_d_idle("drop_idle");
        chk("drop_words", d_words.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < d_words.size()) chk($sformatf("drop_word%0d", k), d_words[k], 8'h10 + 8'(k));
            if (k < d_widths.size()) chk($sformatf("drop_width%0d", k), d_widths[k], 16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
